// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I constants used by fetch, decode and execute:
//                datapath width, canonical NOP encoding, PC increment and a
//                sequential-PC helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int unsigned c_XLEN      = 32;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] c_PC_INC    = 32'd4;

    // Sequential fetch address; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
    function automatic logic [c_XLEN-1:0] pc_next(input logic [c_XLEN-1:0] pc);
        return pc + c_PC_INC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry skid buffer for the instruction-fetch stage.
//                Captures the in-flight memory response when the stage is
//                held, keeps it until the hold ends, and selects between the
//                held entry and the live response for presentation.
//  Ports       : clk, rst_      - clock, synchronous active-low reset
//                flush          - presented entry consumed or squashed
//                squash         - kill the presented entry this cycle
//                req_valid/pc   - in-flight request tracking from the PC logic
//                req_instr      - live memory read data for that request
//                skid_valid     - buffer occupied
//                pc/instr/valid - presented fetch result
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid
    import rv32i_pkg::*;
(
    input  logic              clk,
    input  logic              rst_,
    input  logic              flush,
    input  logic              squash,
    input  logic              req_valid,
    input  logic [c_XLEN-1:0] req_pc,
    input  logic [c_XLEN-1:0] req_instr,
    output logic              skid_valid,
    output logic [c_XLEN-1:0] pc,
    output logic [c_XLEN-1:0] instr,
    output logic              valid
);

    logic              r_skid_valid;
    logic [c_XLEN-1:0] r_skid_pc;
    logic [c_XLEN-1:0] r_skid_instr;
    logic              w_any_valid;

    // Memory read data is only good for one cycle, so a held request must be
    // captured on the first held edge; later held edges keep the first copy.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (req_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_pc    <= req_pc;
            r_skid_instr <= req_instr;
        end
    end

    assign skid_valid  = r_skid_valid;
    assign w_any_valid = r_skid_valid | req_valid;

    always_comb begin
        valid = rst_ & w_any_valid & ~squash;
        pc    = '0;
        instr = c_NOP_INSTR;
        if (valid) begin
            if (r_skid_valid) begin
                pc    = r_skid_pc;
                instr = r_skid_instr;
            end else begin
                pc    = req_pc;
                instr = req_instr;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, issues reads to a
//                synchronous-read instruction memory and presents the
//                {pc, instr, valid} stream to IF/ID, honouring stall and
//                redirect with no lost, duplicated or bubbled fetches.
//  Ports       : clk, rst_            - clock, synchronous active-low reset
//                stall                - downstream hold
//                redirect/redirect_pc - squash and refetch at target
//                imem_en/addr/rdata   - instruction memory interface
//                pc/instr/valid       - presented instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic               valid
);

    logic [c_XLEN-1:0] r_fetch_pc;
    logic [c_XLEN-1:0] r_req_pc;
    logic              r_req_valid;
    logic [c_XLEN-1:0] w_redirect_tgt;
    logic [c_XLEN-1:0] w_issue_pc;
    logic              w_skid_valid;
    logic              w_unused_bits;

    assign w_redirect_tgt = redirect_pc & ~32'd3;
    assign w_issue_pc     = redirect ? w_redirect_tgt : r_fetch_pc;

    // A redirect always issues, even under stall, so the target is presented
    // on the very next cycle.
    assign imem_en   = rst_ & (redirect | ~stall);
    assign imem_addr = w_issue_pc[IMEM_AW+1:2];

    assign w_unused_bits = &{1'b0, w_issue_pc[c_XLEN-1:IMEM_AW+2], w_issue_pc[1:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= '0;
            r_req_valid <= 1'b0;
        end else if (redirect) begin
            r_req_pc    <= w_redirect_tgt;
            r_req_valid <= 1'b1;
            r_fetch_pc  <= pc_next(w_redirect_tgt);
        end else if (!stall) begin
            r_req_pc    <= r_fetch_pc;
            r_req_valid <= 1'b1;
            r_fetch_pc  <= pc_next(r_fetch_pc);
        end else begin
            // Held: the in-flight response moves into the skid buffer.
            r_req_valid <= 1'b0;
        end
    end

    fetch_skid u_fetch_skid (
        .clk        (clk),
        .rst_       (rst_),
        .flush      (redirect | ~stall),
        .squash     (redirect),
        .req_valid  (r_req_valid),
        .req_pc     (r_req_pc),
        .req_instr  (imem_rdata),
        .skid_valid (w_skid_valid),
        .pc         (pc),
        .instr      (instr),
        .valid      (valid)
    );

    // Skid only fills when the request slot empties on the same edge.
    always_ff @(posedge clk) begin
        if (rst_) begin
            assert (!(w_skid_valid && r_req_valid));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit. A table of per-cycle
//                stimulus/expectation records plus hand-written sequences;
//                expectations are queued when driven and compared against
//                the DUT half a cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam int          IMEM_AW = 10;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic               clk;
    logic               rst_;
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic               valid;

    typedef struct {
        logic               rst_n;
        logic               stall;
        logic               redir;
        logic [31:0]        rpc;
        logic               e_en;
        logic [IMEM_AW-1:0] e_addr;
        logic               e_valid;
        logic [31:0]        e_pc;
    } vec_t;

    typedef struct {
        int                 idx;
        logic               e_en;
        logic [IMEM_AW-1:0] e_addr;
        logic               e_valid;
        logic [31:0]        e_pc;
        logic [31:0]        e_instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur;
    int   tests_run;
    int   tests_failed;
    int   vec_idx;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clk         (clk),
        .rst_        (rst_),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data tagged with its word address, one-cycle latency.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {16'hA000, 6'd0, imem_addr};
    end

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] rpc, input logic en,
                                input logic [IMEM_AW-1:0] addr, input logic v,
                                input logic [31:0] p);
        vec_t t;
        t.rst_n = r; t.stall = s; t.redir = rd; t.rpc = rpc;
        t.e_en = en; t.e_addr = addr; t.e_valid = v; t.e_pc = p;
        return t;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] p);
        return {16'hA000, 6'd0, p[11:2]};
    endfunction

    task automatic check(input int idx, input string what,
                         input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL vec%0d %s: got %h, expected %h", idx, what, got, want);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst_        = v.rst_n;
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        e.idx     = vec_idx;
        e.e_en    = v.e_en;
        e.e_addr  = v.e_addr;
        e.e_valid = v.e_valid;
        e.e_pc    = v.e_valid ? v.e_pc : 32'h0;
        e.e_instr = v.e_valid ? mem_word(v.e_pc) : NOP;
        sb.push_back(e);
        vec_idx++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check(cur.idx, "imem_en", {31'd0, imem_en}, {31'd0, cur.e_en});
            if (cur.e_en)
                check(cur.idx, "imem_addr", {22'd0, imem_addr}, {22'd0, cur.e_addr});
            check(cur.idx, "valid", {31'd0, valid}, {31'd0, cur.e_valid});
            check(cur.idx, "pc", pc, cur.e_pc);
            check(cur.idx, "instr", instr, cur.e_instr);
        end
    end

    initial begin
        int budget;
        tests_run    = 0;
        tests_failed = 0;
        vec_idx      = 0;
        rst_         = 1'b0;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;

        //                 rst stl red  redirect_pc   en  addr    v  pc
        // reset held two cycles
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 10'h000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 10'h000, 0, 32'h0));
        // first fetch, then streaming 0,4,8,C
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h001, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h002, 1, 32'h4));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h003, 1, 32'h8));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h004, 1, 32'hC));
        // redirect to 0x40 while pc=0x10 presented
        vecs.push_back(mk(1, 0, 1, 32'h40,        1, 10'h010, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h011, 1, 32'h40));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h012, 1, 32'h44));
        // back to 8, then 3-cycle stall with pc=8 presented
        vecs.push_back(mk(1, 0, 1, 32'h8,         1, 10'h002, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h8));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h8));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h8));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h003, 1, 32'h8));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h004, 1, 32'hC));
        // stall fills skid, then redirect under stall to unaligned 0x103
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h10));
        vecs.push_back(mk(1, 1, 1, 32'h103,       1, 10'h040, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h041, 1, 32'h100));
        // skid full under stall, then reset mid-stall
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h104));
        vecs.push_back(mk(1, 1, 0, 32'h0,         0, 10'h000, 1, 32'h104));
        vecs.push_back(mk(0, 1, 0, 32'h0,         0, 10'h000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h000, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h001, 1, 32'h0));
        // wrap through the top of the address space
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 1, 10'h3FF, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h000, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h001, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,         1, 10'h002, 1, 32'h4));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Longer stall on a redirect target: entry held stable, consumed once.
        run_vec(mk(1, 0, 1, 32'h20, 1, 10'h008, 0, 32'h0));
        run_vec(mk(1, 1, 0, 32'h0,  0, 10'h000, 1, 32'h20));
        for (int k = 0; k < 4; k++)
            run_vec(mk(1, 1, 0, 32'h0, 0, 10'h000, 1, 32'h20));
        run_vec(mk(1, 0, 0, 32'h0,  1, 10'h009, 1, 32'h20));
        run_vec(mk(1, 0, 0, 32'h0,  1, 10'h00A, 1, 32'h24));

        // Stall on the first fetch after reset: nothing lost across the hold.
        run_vec(mk(0, 0, 0, 32'h0,  0, 10'h000, 0, 32'h0));
        run_vec(mk(1, 0, 0, 32'h0,  1, 10'h000, 0, 32'h0));
        run_vec(mk(1, 1, 0, 32'h0,  0, 10'h000, 1, 32'h0));
        run_vec(mk(1, 1, 0, 32'h0,  0, 10'h000, 1, 32'h0));
        run_vec(mk(1, 0, 0, 32'h0,  1, 10'h001, 1, 32'h0));
        run_vec(mk(1, 0, 0, 32'h0,  1, 10'h002, 1, 32'h4));

        budget = 0;
        while (sb.size() > 0 && budget < 8) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
